// File: rtl/ibuf_pkg.sv
// Shared definitions for the input line buffer writer and its router model.
//   - Address field widths of the buffer write port (bank/row/col).
//   - Helper functions for the derived tile geometry (BUFW, LM, BUFH).
//   - wr_state_e: writer FSM state, shared so the router side can decode it.
// Optional feature macro: IBUF_WRITER_PAD_EN adds the PAD state.
package ibuf_pkg;

  localparam int unsigned BANK_W = 8;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 28;

  // Buffer width: POX output columns plus the left halo of the kernel.
  function automatic int unsigned calc_bufw(input int unsigned pox,
                                            input int unsigned stride,
                                            input int unsigned ksize);
    return pox * stride + ksize / 2;
  endfunction

  // Input lines per tile.
  function automatic int unsigned calc_lm(input int unsigned poy,
                                          input int unsigned stride);
    return (stride + 1) * poy - stride;
  endfunction

  // Rows per bank (ceil(lm / poy)).
  function automatic int unsigned calc_bufh(input int unsigned lm,
                                            input int unsigned poy);
    return (lm + poy - 1) / poy;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    FULL
`ifdef IBUF_WRITER_PAD_EN
    ,
    PAD
`endif
  } wr_state_e;

endpackage

// File: rtl/ibuf_addr_gen.sv
// Write-address generator for one input tile.
// Walks col 0..BUFW-1 within a line; at the end of each line advances the
// line count and the bank, and the row when the bank wraps, so line L lands
// on bank L mod POY, row L div POY without any divider.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero all counters (start of tile)
//   step        advance to the next word address
//   last_col    current col is BUFW-1
//   last_word   current address is the final word of the tile
//   bank/row/col current write address
module ibuf_addr_gen
  import ibuf_pkg::*;
#(
  parameter int unsigned BUFW = 17,
  parameter int unsigned POY  = 3,
  parameter int unsigned BUFH = 2,
  parameter int unsigned LM   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  output logic              last_col,
  output logic              last_word,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col
);

  localparam int unsigned LINE_W = 16;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BUFW - 1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(POY - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(BUFH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LM - 1);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign last_col  = (col_q == COL_LAST);
  assign last_word = last_col && (line_q == LINE_LAST);
  assign bank      = bank_q;
  assign row       = row_q;
  assign col       = col_q;

  always_comb begin
    col_d  = col_q;
    bank_d = bank_q;
    row_d  = row_q;
    line_d = line_q;
    if (clear) begin
      col_d  = '0;
      bank_d = '0;
      row_d  = '0;
      line_d = '0;
    end else if (step) begin
      if (last_word) begin
        col_d  = '0;
        bank_d = '0;
        row_d  = '0;
        line_d = '0;
      end else if (last_col) begin
        col_d  = '0;
        line_d = line_q + LINE_W'(1);
        if (bank_q == BANK_LAST) begin
          bank_d = '0;
          row_d  = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          bank_d = bank_q + BANK_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      bank_q <= '0;
      row_q  <= '0;
      line_q <= '0;
    end else begin
      col_q  <= col_d;
      bank_q <= bank_d;
      row_q  <= row_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/ibuf_tile_writer.sv
// Write-side master of the input line buffer.
// Accepts a raster stream of activation words (valid/ready) and scatters one
// tile of LM lines x BUFW columns over POY banks. Each accepted word is
// written one cycle after its handshake; the tile is then held as full until
// the router acknowledges it.
// Optional feature macro: IBUF_WRITER_PAD_EN -- the first KSIZE/2 columns of
// every line are written with zeros generated locally (no stream word used).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tile_start           start filling a tile (IDLE only)
//   in_data/valid/ready  input stream
//   wdata/wbank/wrow/wcol/wen  registered buffer write port
//   tile_full            tile complete, waiting for tile_ack
//   tile_ack             router has consumed the tile (FULL only)
//   busy                 filling or draining
module ibuf_tile_writer
  import ibuf_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned POY    = 3,
  parameter int unsigned POX    = 16,
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tile_start,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     wdata,
  output logic [BANK_W-1:0] wbank,
  output logic [ROW_W-1:0]  wrow,
  output logic [COL_W-1:0]  wcol,
  output logic              wen,
  output logic              tile_full,
  input  logic              tile_ack,
  output logic              busy
);

  localparam int unsigned BUFW = calc_bufw(POX, STRIDE, KSIZE);
  localparam int unsigned LM   = calc_lm(POY, STRIDE);
  localparam int unsigned BUFH = calc_bufh(LM, POY);
`ifdef IBUF_WRITER_PAD_EN
  localparam int unsigned PAD_COLS = KSIZE / 2;
`endif

  wr_state_e state_q, state_d;

  logic clear;
  logic step;
`ifdef IBUF_WRITER_PAD_EN
  logic pad_write;
`endif

  logic              last_col;
  logic              last_word;
  logic [BANK_W-1:0] cur_bank;
  logic [ROW_W-1:0]  cur_row;
  logic [COL_W-1:0]  cur_col;

  logic              wen_q,   wen_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BANK_W-1:0] wbank_q, wbank_d;
  logic [ROW_W-1:0]  wrow_q,  wrow_d;
  logic [COL_W-1:0]  wcol_q,  wcol_d;

  ibuf_addr_gen #(
    .BUFW (BUFW),
    .POY  (POY),
    .BUFH (BUFH),
    .LM   (LM)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .step      (step),
    .last_col  (last_col),
    .last_word (last_word),
    .bank      (cur_bank),
    .row       (cur_row),
    .col       (cur_col)
  );

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    step     = 1'b0;
    in_ready = 1'b0;
`ifdef IBUF_WRITER_PAD_EN
    pad_write = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tile_start) begin
          clear = 1'b1;
`ifdef IBUF_WRITER_PAD_EN
          state_d = (PAD_COLS > 0) ? PAD : FILL;
`else
          state_d = FILL;
`endif
        end
      end
`ifdef IBUF_WRITER_PAD_EN
      PAD: begin
        step      = 1'b1;
        pad_write = 1'b1;
        if (cur_col == COL_W'(PAD_COLS - 1)) begin
          state_d = FILL;
        end
      end
`endif
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          step = 1'b1;
          if (last_col) begin
            if (last_word) begin
              state_d = DRAIN;
`ifdef IBUF_WRITER_PAD_EN
            end else if (PAD_COLS > 0) begin
              state_d = PAD;
`endif
            end
          end
        end
      end
      DRAIN: begin
        state_d = FULL;
      end
      FULL: begin
        // tile_start in the same cycle is dropped on purpose.
        if (tile_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write port: capture the address of the word written this cycle; hold
  // address and data when no write is issued.
  always_comb begin
    wen_d   = step;
    wdata_d = wdata_q;
    wbank_d = wbank_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    if (step) begin
`ifdef IBUF_WRITER_PAD_EN
      wdata_d = pad_write ? '0 : in_data;
`else
      wdata_d = in_data;
`endif
      wbank_d = cur_bank;
      wrow_d  = cur_row;
      wcol_d  = cur_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wbank_q <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wbank_q <= wbank_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
    end
  end

  assign wen       = wen_q;
  assign wdata     = wdata_q;
  assign wbank     = wbank_q;
  assign wrow      = wrow_q;
  assign wcol      = wcol_q;
  assign tile_full = (state_q == FULL);
`ifdef IBUF_WRITER_PAD_EN
  assign busy      = (state_q == FILL) || (state_q == DRAIN) || (state_q == PAD);
`else
  assign busy      = (state_q == FILL) || (state_q == DRAIN);
`endif

endmodule
